// File: rtl/ingreso_monto.sv
// Keypad amount entry: collects decimal keys into a BCD buffer with
// backspace/clear, and on Enter converts the buffer to binary one digit
// per cycle (most significant first), then strobes the result on monto.
module ingreso_monto #(
    parameter int MAX_DIGITOS = 9,
    parameter int ANCHO       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             habilitar,
    input  logic             tecla_stb,
    input  logic [3:0]       tecla,
    output logic [ANCHO-1:0] monto,
    output logic             monto_stb,
    output logic             ocupado,
    output logic [3:0]       cuenta_digitos,
    output logic             desborde
);

    localparam int BUF_W = 4 * MAX_DIGITOS;

    localparam logic [3:0] TECLA_BORRAR  = 4'hA;
    localparam logic [3:0] TECLA_LIMPIAR = 4'hB;
    localparam logic [3:0] TECLA_ENTRAR  = 4'hC;

    typedef enum logic [1:0] {
        ESPERA,
        CAPTURA,
        CONVERSION
    } estado_t;

    estado_t          estado, estado_sig;
    logic [BUF_W-1:0] buffer, buffer_sig;
    logic [3:0]       cuenta, cuenta_sig;
    logic [3:0]       indice, indice_sig;
    logic [ANCHO-1:0] acc, acc_sig;
    logic [ANCHO-1:0] monto_sig;
    logic             stb_sig;
    logic             ocupado_sig;
    logic             desborde_sig;

    logic             tecla_ok;
    logic [3:0]       digito;
    logic [ANCHO-1:0] acc_paso;

    // acc*10 + d, with the x10 built from shifts at ANCHO width
    function automatic logic [ANCHO-1:0] paso_conversion(input logic [ANCHO-1:0] a,
                                                         input logic [3:0]       d);
        return (a << 3) + (a << 1) + ANCHO'(d);
    endfunction

    assign tecla_ok       = tecla_stb && habilitar;
    assign digito         = 4'(buffer >> {indice, 2'b00});
    assign acc_paso       = paso_conversion(acc, digito);
    assign cuenta_digitos = cuenta;

    // Next-state and datapath decode; pulses default low every cycle
    always_comb begin
        estado_sig   = estado;
        buffer_sig   = buffer;
        cuenta_sig   = cuenta;
        indice_sig   = indice;
        acc_sig      = acc;
        monto_sig    = monto;
        stb_sig      = 1'b0;
        ocupado_sig  = ocupado;
        desborde_sig = 1'b0;

        case (estado)
            ESPERA: begin
                if (tecla_ok && tecla <= 4'd9) begin
                    buffer_sig = BUF_W'(tecla);
                    cuenta_sig = 4'd1;
                    estado_sig = CAPTURA;
                end
            end

            CAPTURA: begin
                // Losing habilitar abandons the entry, even with a key present
                if (!habilitar) begin
                    buffer_sig = '0;
                    cuenta_sig = 4'd0;
                    estado_sig = ESPERA;
                end else if (tecla_stb) begin
                    if (tecla <= 4'd9) begin
                        if (cuenta < 4'(MAX_DIGITOS)) begin
                            buffer_sig = (buffer << 4) | BUF_W'(tecla);
                            cuenta_sig = cuenta + 4'd1;
                        end else begin
                            desborde_sig = 1'b1;
                        end
                    end else if (tecla == TECLA_BORRAR) begin
                        buffer_sig = buffer >> 4;
                        cuenta_sig = cuenta - 4'd1;
                        if (cuenta == 4'd1) estado_sig = ESPERA;
                    end else if (tecla == TECLA_LIMPIAR) begin
                        buffer_sig = '0;
                        cuenta_sig = 4'd0;
                        estado_sig = ESPERA;
                    end else if (tecla == TECLA_ENTRAR) begin
                        acc_sig     = '0;
                        indice_sig  = cuenta - 4'd1;
                        ocupado_sig = 1'b1;
                        estado_sig  = CONVERSION;
                    end
                end
            end

            CONVERSION: begin
                acc_sig = acc_paso;
                if (indice == 4'd0) begin
                    monto_sig   = acc_paso;
                    stb_sig     = 1'b1;
                    buffer_sig  = '0;
                    cuenta_sig  = 4'd0;
                    ocupado_sig = 1'b0;
                    estado_sig  = ESPERA;
                end else begin
                    indice_sig = indice - 4'd1;
                end
            end

            default: estado_sig = ESPERA;
        endcase
    end

    // State and datapath registers; reset clears everything including monto
    always_ff @(posedge clk) begin
        if (rst) begin
            estado    <= ESPERA;
            buffer    <= '0;
            cuenta    <= 4'd0;
            indice    <= 4'd0;
            acc       <= '0;
            monto     <= '0;
            monto_stb <= 1'b0;
            ocupado   <= 1'b0;
            desborde  <= 1'b0;
        end else begin
            estado    <= estado_sig;
            buffer    <= buffer_sig;
            cuenta    <= cuenta_sig;
            indice    <= indice_sig;
            acc       <= acc_sig;
            monto     <= monto_sig;
            monto_stb <= stb_sig;
            ocupado   <= ocupado_sig;
            desborde  <= desborde_sig;
        end
    end

endmodule

// File: tb/tb_ingreso_monto.sv
// Directed bench for ingreso_monto: key sequences with hand-computed amounts.
module tb_ingreso_monto;

    logic        clk = 1'b0;
    logic        rst;
    logic        habilitar;
    logic        tecla_stb;
    logic [3:0]  tecla;
    logic [31:0] monto;
    logic        monto_stb;
    logic        ocupado;
    logic [3:0]  cuenta_digitos;
    logic        desborde;

    int compared = 0;
    int mismatched = 0;

    ingreso_monto #(.MAX_DIGITOS(9), .ANCHO(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .habilitar      (habilitar),
        .tecla_stb      (tecla_stb),
        .tecla          (tecla),
        .monto          (monto),
        .monto_stb      (monto_stb),
        .ocupado        (ocupado),
        .cuenta_digitos (cuenta_digitos),
        .desborde       (desborde)
    );

    always #5 clk = ~clk;

    // Present one key for one edge; returns 1 time unit after that edge
    task automatic press(input logic [3:0] k);
        tecla_stb = 1'b1;
        tecla     = k;
        @(posedge clk); #1;
        tecla_stb = 1'b0;
        tecla     = 4'h0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Called right after Enter was sampled; waits (bounded) for monto_stb,
    // counting sampled cycles with ocupado high before it
    task automatic wait_stb(output int ocup, output logic got);
        ocup = 0;
        got  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (monto_stb) begin
                got = 1'b1;
                break;
            end
            if (ocupado) ocup++;
            @(posedge clk); #1;
        end
    endtask

    task automatic count_stb(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            if (monto_stb) cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; habilitar = 1'b0; tecla_stb = 1'b0; tecla = 4'h0;
        idle(3);
        rst = 1'b0;
        compared++;
        if ({monto, monto_stb, ocupado, cuenta_digitos, desborde} !== 39'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: got monto=%0d stb=%b ocup=%b cuenta=%0d desb=%b, expected all 0",
                     monto, monto_stb, ocupado, cuenta_digitos, desborde);
        end
    endtask

    task automatic test_basic;
        logic [3:0] keys [4] = '{4'd4, 4'd5, 4'd0, 4'd0};
        int ocup;
        logic got;
        habilitar = 1'b1;
        for (int i = 0; i < 4; i++) begin
            press(keys[i]);
            compared++;
            if (cuenta_digitos !== 4'(i + 1)) begin
                mismatched++;
                $display("FAIL basic_cuenta[%0d]: got %0d, expected %0d", i, cuenta_digitos, i + 1);
            end
        end
        press(4'hC);
        wait_stb(ocup, got);
        compared++;
        if (got !== 1'b1) begin
            mismatched++;
            $display("FAIL basic_stb_seen: got %b, expected 1", got);
        end
        compared++;
        if (ocup !== 4) begin
            mismatched++;
            $display("FAIL basic_ocupado_cycles: got %0d, expected 4", ocup);
        end
        compared++;
        if (monto !== 32'd4500) begin
            mismatched++;
            $display("FAIL basic_monto: got %0d, expected 4500", monto);
        end
        compared++;
        if (ocupado !== 1'b0 || cuenta_digitos !== 4'd0) begin
            mismatched++;
            $display("FAIL basic_at_stb: got ocup=%b cuenta=%0d, expected 0/0", ocupado, cuenta_digitos);
        end
        idle(1);
        compared++;
        if (monto_stb !== 1'b0 || monto !== 32'd4500) begin
            mismatched++;
            $display("FAIL basic_pulse_hold: got stb=%b monto=%0d, expected 0/4500", monto_stb, monto);
        end
    endtask

    task automatic test_backspace_clear;
        int ocup, cnt;
        logic got;
        press(4'd1); press(4'd2); press(4'd3); press(4'hA);
        compared++;
        if (cuenta_digitos !== 4'd2) begin
            mismatched++;
            $display("FAIL bksp_cuenta: got %0d, expected 2", cuenta_digitos);
        end
        press(4'd9);
        press(4'hC);
        wait_stb(ocup, got);
        compared++;
        if (got !== 1'b1 || monto !== 32'd129 || ocup !== 3) begin
            mismatched++;
            $display("FAIL bksp_monto: got stb=%b monto=%0d ocup=%0d, expected 1/129/3", got, monto, ocup);
        end
        press(4'd7); press(4'hB);
        compared++;
        if (cuenta_digitos !== 4'd0) begin
            mismatched++;
            $display("FAIL clear_cuenta: got %0d, expected 0", cuenta_digitos);
        end
        press(4'hC);
        count_stb(6, cnt);
        compared++;
        if (cnt !== 0 || ocupado !== 1'b0 || monto !== 32'd129) begin
            mismatched++;
            $display("FAIL clear_enter_ignored: got stb_count=%0d ocup=%b monto=%0d, expected 0/0/129",
                     cnt, ocupado, monto);
        end
    endtask

    task automatic test_overflow;
        int ocup;
        logic got;
        for (int i = 0; i < 9; i++) press(4'd9);
        compared++;
        if (cuenta_digitos !== 4'd9 || desborde !== 1'b0) begin
            mismatched++;
            $display("FAIL ovf_full: got cuenta=%0d desb=%b, expected 9/0", cuenta_digitos, desborde);
        end
        press(4'd5);
        compared++;
        if (desborde !== 1'b1 || cuenta_digitos !== 4'd9) begin
            mismatched++;
            $display("FAIL ovf_pulse: got desb=%b cuenta=%0d, expected 1/9", desborde, cuenta_digitos);
        end
        idle(1);
        compared++;
        if (desborde !== 1'b0) begin
            mismatched++;
            $display("FAIL ovf_single: got desb=%b, expected 0", desborde);
        end
        press(4'hC);
        wait_stb(ocup, got);
        compared++;
        if (got !== 1'b1 || monto !== 32'h3B9AC9FF || ocup !== 9) begin
            mismatched++;
            $display("FAIL ovf_monto: got stb=%b monto=%0d ocup=%0d, expected 1/999999999/9", got, monto, ocup);
        end
    endtask

    task automatic test_habilitar;
        int ocup, cnt;
        logic got;
        press(4'd2); press(4'd0);
        habilitar = 1'b0;
        idle(1);
        compared++;
        if (cuenta_digitos !== 4'd0) begin
            mismatched++;
            $display("FAIL hab_abort_cuenta: got %0d, expected 0", cuenta_digitos);
        end
        habilitar = 1'b1;
        press(4'hC);
        count_stb(5, cnt);
        compared++;
        if (cnt !== 0 || ocupado !== 1'b0) begin
            mismatched++;
            $display("FAIL hab_no_stb: got stb_count=%0d ocup=%b, expected 0/0", cnt, ocupado);
        end
        press(4'd6); press(4'hC);
        wait_stb(ocup, got);
        compared++;
        if (got !== 1'b1 || monto !== 32'd6 || ocup !== 1) begin
            mismatched++;
            $display("FAIL hab_monto: got stb=%b monto=%0d ocup=%0d, expected 1/6/1", got, monto, ocup);
        end
    endtask

    task automatic test_reset_mid;
        int ocup, cnt;
        logic got;
        press(4'd8); press(4'd8); press(4'hC);
        compared++;
        if (ocupado !== 1'b1) begin
            mismatched++;
            $display("FAIL rstmid_busy: got ocup=%b, expected 1", ocupado);
        end
        rst = 1'b1;
        tecla_stb = 1'b1; tecla = 4'd4;
        @(posedge clk); #1;
        rst = 1'b0; tecla_stb = 1'b0;
        count_stb(5, cnt);
        compared++;
        if (cnt !== 0 || {monto, ocupado, cuenta_digitos, desborde} !== 38'd0) begin
            mismatched++;
            $display("FAIL rstmid_abort: got stb_count=%0d monto=%0d ocup=%b cuenta=%0d, expected 0/0/0/0",
                     cnt, monto, ocupado, cuenta_digitos);
        end
        press(4'd3); press(4'hC);
        wait_stb(ocup, got);
        compared++;
        if (got !== 1'b1 || monto !== 32'd3) begin
            mismatched++;
            $display("FAIL rstmid_after: got stb=%b monto=%0d, expected 1/3", got, monto);
        end
    endtask

    task automatic test_ignored_keys;
        press(4'd1); press(4'd2); press(4'hE); press(4'hF); press(4'hD);
        compared++;
        if (cuenta_digitos !== 4'd2) begin
            mismatched++;
            $display("FAIL ign_codes_cuenta: got %0d, expected 2", cuenta_digitos);
        end
        press(4'hC);
        press(4'd5);
        compared++;
        if (ocupado !== 1'b1 || monto_stb !== 1'b0 || cuenta_digitos !== 4'd2) begin
            mismatched++;
            $display("FAIL ign_conv_mid: got ocup=%b stb=%b cuenta=%0d, expected 1/0/2",
                     ocupado, monto_stb, cuenta_digitos);
        end
        press(4'hB);
        compared++;
        if (monto_stb !== 1'b1 || monto !== 32'd12 || cuenta_digitos !== 4'd0) begin
            mismatched++;
            $display("FAIL ign_conv_result: got stb=%b monto=%0d cuenta=%0d, expected 1/12/0",
                     monto_stb, monto, cuenta_digitos);
        end
    endtask

    task automatic test_back_to_back;
        int ocup;
        logic got;
        press(4'd1); press(4'hC);
        idle(1);
        compared++;
        if (monto_stb !== 1'b1 || monto !== 32'd1) begin
            mismatched++;
            $display("FAIL b2b_first: got stb=%b monto=%0d, expected 1/1", monto_stb, monto);
        end
        press(4'd7);
        compared++;
        if (cuenta_digitos !== 4'd1 || monto_stb !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_accept: got cuenta=%0d stb=%b, expected 1/0", cuenta_digitos, monto_stb);
        end
        press(4'hC);
        wait_stb(ocup, got);
        compared++;
        if (got !== 1'b1 || monto !== 32'd7) begin
            mismatched++;
            $display("FAIL b2b_second: got stb=%b monto=%0d, expected 1/7", got, monto);
        end
        press(4'd0); press(4'hC);
        wait_stb(ocup, got);
        compared++;
        if (got !== 1'b1 || monto !== 32'd0) begin
            mismatched++;
            $display("FAIL zero_entry: got stb=%b monto=%0d, expected 1/0", got, monto);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backspace_clear();
        test_overflow();
        test_habilitar();
        test_reset_mid();
        test_ignored_keys();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ingreso_monto.md
# ingreso_monto

Keypad amount-entry stage that sits directly upstream of the ATM transaction controller. It collects decimal key presses into a BCD buffer, supports backspace and clear, and on Enter converts the buffer to binary one digit per cycle. It then presents the result on `monto` with a one-cycle `monto_stb`, which is exactly the amount/strobe pair the controller consumes in its deposit and withdrawal states.

## Interface
- `MAX_DIGITOS`, default 9: buffer depth in decimal digits. 9 guarantees that 999 999 999 fits in `ANCHO`.
- `ANCHO`, default 32: width of `monto`.
- `clk`  in  1: clock, rising-edge.
- `rst`  in  1: reset, synchronous, active-high.
- `habilitar`  in  1: entry allowed. Driven high while the controller is in deposit or withdrawal.
- `tecla_stb`  in  1: one-cycle key-valid strobe.
- `tecla`  in  4: key code. 0x0–0x9 = digit, 0xA = backspace, 0xB = clear, 0xC = enter, 0xD–0xF = ignored.
- `monto`  out  ANCHO: converted amount. Held until the next conversion completes.
- `monto_stb`  out  1: one-cycle pulse, `monto` valid.
- `ocupado`  out  1: high while converting.
- `cuenta_digitos`  out  4: digits currently buffered (display feedback).
- `desborde`  out  1: one-cycle pulse when a digit is rejected because the buffer is full.

## Operation
- Reset values: all outputs 0, buffer 0, state ESPERA.
- Internal storage:
  - BCD buffer, 4·MAX_DIGITOS bits. Newest digit sits in the low nibble; an accepted digit shifts the buffer left by one nibble.
  - Digit counter.
  - Conversion index.
  - Accumulator, ANCHO bits.
- State ESPERA (buffer empty):
  - Digit key with `habilitar`=1 → store digit, count=1, go to CAPTURA.
  - Backspace, clear and enter are ignored.
- State CAPTURA:
  - Digit key:
    - count < MAX_DIGITOS → shift in, count+1.
    - count = MAX_DIGITOS → buffer unchanged, `desborde` pulses.
  - Backspace → buffer shifts right one nibble, count−1. If count reaches 0, go to ESPERA.
  - Clear → buffer 0, count 0, go to ESPERA.
  - Enter → accumulator 0, index = count−1, `ocupado`=1, go to CONVERSION.
  - `habilitar` sampled low → buffer 0, count 0, go to ESPERA. This takes priority over any key in the same cycle.
- State CONVERSION:
  - One digit per cycle, most significant first: acc ← acc·10 + digit[index]. Compute acc·10 as (acc<<3)+(acc<<1) at ANCHO width.
  - On the cycle that processes index 0:
    - `monto` ← final value and `monto_stb` ← 1.
    - Buffer 0, count 0, `ocupado` ← 0, go to ESPERA.
  - All keys are ignored. `habilitar` is ignored: a conversion in progress always completes.
- Leading zeros are accepted and count toward the limit. Entering "0" then Enter produces `monto`=0 with a strobe.
- Codes 0xD–0xF are ignored in every state. Keys with `habilitar`=0 are ignored in every state.
- Every transition is taken only on a cycle where `tecla_stb`=1, except conversion stepping and the `habilitar`-low abort.

## Timing
- Key effects (buffer, `cuenta_digitos`, state) are visible the cycle after the edge that samples `tecla_stb`.
- `desborde` and `monto_stb` are registered, single-cycle pulses.
- Conversion latency: enter sampled at edge E, N digits buffered.
  - `ocupado` is high for cycles E+1 .. E+N.
  - `monto_stb`=1 and the new `monto` appear after edge E+N. `ocupado` is 0 in that cycle.
- Back-to-back entry is possible: a digit key is accepted in the cycle `monto_stb` is high, since the state is already ESPERA.
- `rst` mid-conversion aborts with no `monto_stb`, and `monto` returns to 0.
- Simultaneous `rst` and key: reset wins.

## Test plan
- Keys 4,5,0,0 then Enter → `ocupado` high for 4 cycles, then `monto`=4500 with `monto_stb` high for exactly 1 cycle. `cuenta_digitos` steps 1,2,3,4, then returns to 0.
- Keys 1,2,3, backspace, 9, Enter → `monto`=129. Keys 7, clear, Enter → no strobe, state ESPERA.
- Nine 9s, then a 10th digit 5, then Enter → `desborde` pulses once on the 10th key, then `monto`=999 999 999 (0x3B9AC9FF).
- Keys 2,0 with `habilitar` dropped before Enter → buffer cleared, no strobe. The following sequence 6, Enter → `monto`=6.
- Keys 8,8, Enter; assert `rst` one cycle into CONVERSION → no `monto_stb`, all outputs 0. A subsequent 3, Enter → `monto`=3.
- Keys pressed during CONVERSION (digit 5 and clear), plus codes 0xE/0xF while in CAPTURA → no effect on the result or on `cuenta_digitos`.
